// File: rtl/ahb_bus_arbiter.sv
// Two-master AHB arbiter: round-robin grant, burst hold, tenure limit, pipelined HWDATA.
// Define AHB_ARB_FIXED_PRIO_EN for fixed M0 priority with tenure preemption of M1 only.
module ahb_bus_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int MAX_HOLD   = 16
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HBUSREQ0,
    input  logic                  HBUSREQ1,
    output logic                  HGRANT0,
    output logic                  HGRANT1,
    input  logic [ADDR_WIDTH-1:0] HADDR_M0,
    input  logic [ADDR_WIDTH-1:0] HADDR_M1,
    input  logic [1:0]            HTRANS_M0,
    input  logic [1:0]            HTRANS_M1,
    input  logic                  HWRITE_M0,
    input  logic                  HWRITE_M1,
    input  logic [2:0]            HSIZE_M0,
    input  logic [2:0]            HSIZE_M1,
    input  logic [2:0]            HBURST_M0,
    input  logic [2:0]            HBURST_M1,
    input  logic [3:0]            HPROT_M0,
    input  logic [3:0]            HPROT_M1,
    input  logic [DATA_WIDTH-1:0] HWDATA_M0,
    input  logic [DATA_WIDTH-1:0] HWDATA_M1,
    input  logic                  HREADY,
    output logic [ADDR_WIDTH-1:0] HADDR,
    output logic [1:0]            HTRANS,
    output logic                  HWRITE,
    output logic [2:0]            HSIZE,
    output logic [2:0]            HBURST,
    output logic [3:0]            HPROT,
    output logic [DATA_WIDTH-1:0] HWDATA,
    output logic                  HMASTER
);

    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam logic [1:0] TR_BUSY = 2'b01;
    localparam logic [1:0] TR_SEQ  = 2'b11;

    typedef enum logic [1:0] {
        PARK = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t        state;
    logic          data_owner;
    logic [HW-1:0] hold_cnt;
`ifndef AHB_ARB_FIXED_PRIO_EN
    logic          rr_ptr;
`endif

    logic       own;
    logic [1:0] trans_own;
    logic       req_own;
    logic       req_oth;
    logic       arb_pt;
    logic       hold_max;
    logic       preempt;
    logic       winner;
    logic       take;
    logic       take_m;
    logic       to_park;

    always_comb begin
        own       = (state == OWN1);
        trans_own = own ? HTRANS_M1 : HTRANS_M0;
        req_own   = own ? HBUSREQ1 : HBUSREQ0;
        req_oth   = own ? HBUSREQ0 : HBUSREQ1;
        // Burst beats (SEQ) and BUSY slots never hand the bus over
        arb_pt    = HREADY && (trans_own != TR_SEQ) &&
                    (trans_own != TR_BUSY);
        hold_max  = (hold_cnt >= HW'(MAX_HOLD));
`ifdef AHB_ARB_FIXED_PRIO_EN
        preempt   = hold_max && own;
        winner    = ~HBUSREQ0;
`else
        preempt   = hold_max;
        winner    = (HBUSREQ0 && HBUSREQ1) ? rr_ptr : HBUSREQ1;
`endif
        take      = 1'b0;
        take_m    = 1'b0;
        to_park   = 1'b0;
        if (state == PARK) begin
            take   = HBUSREQ0 | HBUSREQ1;
            take_m = winner;
        end else if (arb_pt) begin
            if (req_oth && (!req_own || preempt)) begin
                take   = 1'b1;
                take_m = ~own;
            end else if (!req_own) begin
                to_park = 1'b1;
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state      <= PARK;
            HGRANT0    <= 1'b0;
            HGRANT1    <= 1'b0;
            HMASTER    <= 1'b0;
            data_owner <= 1'b0;
            hold_cnt   <= '0;
`ifndef AHB_ARB_FIXED_PRIO_EN
            rr_ptr     <= 1'b0;
`endif
        end else if (HREADY) begin
            data_owner <= HMASTER;
            if (take) begin
                state    <= take_m ? OWN1 : OWN0;
                HGRANT0  <= ~take_m;
                HGRANT1  <= take_m;
                HMASTER  <= take_m;
                hold_cnt <= '0;
`ifndef AHB_ARB_FIXED_PRIO_EN
                if (state != PARK)
                    rr_ptr <= own;
`endif
            end else if (to_park) begin
                state    <= PARK;
                HGRANT0  <= 1'b0;
                HGRANT1  <= 1'b0;
                hold_cnt <= '0;
            end else if (state != PARK && req_oth && !hold_max) begin
                hold_cnt <= hold_cnt + HW'(1);
            end
        end
    end

    always_comb begin
        HADDR  = '0;
        HTRANS = 2'b00;
        HWRITE = 1'b0;
        HSIZE  = 3'd0;
        HBURST = 3'd0;
        HPROT  = 4'd0;
        case (state)
            OWN0: begin
                HADDR  = HADDR_M0;
                HTRANS = HTRANS_M0;
                HWRITE = HWRITE_M0;
                HSIZE  = HSIZE_M0;
                HBURST = HBURST_M0;
                HPROT  = HPROT_M0;
            end
            OWN1: begin
                HADDR  = HADDR_M1;
                HTRANS = HTRANS_M1;
                HWRITE = HWRITE_M1;
                HSIZE  = HSIZE_M1;
                HBURST = HBURST_M1;
                HPROT  = HPROT_M1;
            end
            default: ;
        endcase
    end

    assign HWDATA = data_owner ? HWDATA_M1 : HWDATA_M0;

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Self-checking bench for ahb_bus_arbiter: directed tables plus
// randomized traffic against a behavioural ownership model.
module tb_ahb_bus_arbiter;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int MH = 4;

    logic          HCLK = 1'b0;
    logic          HRESETn;
    logic          HBUSREQ0, HBUSREQ1;
    logic          HGRANT0, HGRANT1;
    logic [AW-1:0] HADDR_M0, HADDR_M1;
    logic [1:0]    HTRANS_M0, HTRANS_M1;
    logic          HWRITE_M0, HWRITE_M1;
    logic [2:0]    HSIZE_M0, HSIZE_M1;
    logic [2:0]    HBURST_M0, HBURST_M1;
    logic [3:0]    HPROT_M0, HPROT_M1;
    logic [DW-1:0] HWDATA_M0, HWDATA_M1;
    logic          HREADY;
    logic [AW-1:0] HADDR;
    logic [1:0]    HTRANS;
    logic          HWRITE;
    logic [2:0]    HSIZE;
    logic [2:0]    HBURST;
    logic [3:0]    HPROT;
    logic [DW-1:0] HWDATA;
    logic          HMASTER;

    always #5 HCLK = ~HCLK;

    ahb_bus_arbiter #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .MAX_HOLD(MH)
    ) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .HBUSREQ0(HBUSREQ0), .HBUSREQ1(HBUSREQ1),
        .HGRANT0(HGRANT0), .HGRANT1(HGRANT1),
        .HADDR_M0(HADDR_M0), .HADDR_M1(HADDR_M1),
        .HTRANS_M0(HTRANS_M0), .HTRANS_M1(HTRANS_M1),
        .HWRITE_M0(HWRITE_M0), .HWRITE_M1(HWRITE_M1),
        .HSIZE_M0(HSIZE_M0), .HSIZE_M1(HSIZE_M1),
        .HBURST_M0(HBURST_M0), .HBURST_M1(HBURST_M1),
        .HPROT_M0(HPROT_M0), .HPROT_M1(HPROT_M1),
        .HWDATA_M0(HWDATA_M0), .HWDATA_M1(HWDATA_M1),
        .HREADY(HREADY),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
        .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT),
        .HWDATA(HWDATA), .HMASTER(HMASTER)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    typedef struct {
        bit       r0, r1;
        bit [1:0] t0, t1;
        bit       rdy;
        bit       g0, g1, hm, dw;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(bit r0, bit r1, bit [1:0] t0, bit [1:0] t1,
                               bit rdy, bit g0, bit g1, bit hm, bit dw);
        vec_t x;
        x.r0 = r0; x.r1 = r1; x.t0 = t0; x.t1 = t1; x.rdy = rdy;
        x.g0 = g0; x.g1 = g1; x.hm = hm; x.dw = dw;
        return x;
    endfunction

    // Reference model: owner -1 means parked
    int m_owner;
    bit m_rr;
    int m_hold;
    bit m_hm;
    bit m_dw;

    task automatic model_reset();
        m_owner = -1; m_rr = 0; m_hold = 0; m_hm = 0; m_dw = 0;
    endtask

    task automatic give(input int w);
        m_owner = w; m_hm = w[0]; m_hold = 0;
    endtask

    task automatic model_step();
        int x;
        bit rx, ro, bnd, pre;
        logic [1:0] tx;
        bit fixed;
`ifdef AHB_ARB_FIXED_PRIO_EN
        fixed = 1;
`else
        fixed = 0;
`endif
        if (!HREADY) return;
        m_dw = m_hm;
        if (m_owner < 0) begin
            if (HBUSREQ0 || HBUSREQ1) begin
                if (HBUSREQ0 && HBUSREQ1) give(fixed ? 0 : int'(m_rr));
                else give(HBUSREQ1 ? 1 : 0);
            end
        end else begin
            x = m_owner;
            tx = (x == 1) ? HTRANS_M1 : HTRANS_M0;
            rx = (x == 1) ? HBUSREQ1 : HBUSREQ0;
            ro = (x == 1) ? HBUSREQ0 : HBUSREQ1;
            bnd = (tx == 2'b00) || (tx == 2'b10);
            pre = (m_hold >= MH) && (!fixed || x == 1);
            if (bnd && ro && (!rx || pre)) begin
                m_rr = x[0];
                give(1 - x);
            end else if (bnd && !rx) begin
                m_owner = -1;
                m_hold = 0;
            end else if (ro && m_hold < MH) begin
                m_hold++;
            end
        end
    endtask

    task automatic idle_inputs();
        HBUSREQ0 = 0; HBUSREQ1 = 0;
        HTRANS_M0 = 0; HTRANS_M1 = 0;
        HADDR_M0 = 0; HADDR_M1 = 0;
        HWRITE_M0 = 0; HWRITE_M1 = 0;
        HSIZE_M0 = 0; HSIZE_M1 = 0;
        HBURST_M0 = 0; HBURST_M1 = 0;
        HPROT_M0 = 0; HPROT_M1 = 0;
        HWDATA_M0 = 32'hAAAA_0000;
        HWDATA_M1 = 32'hBBBB_1111;
        HREADY = 1;
    endtask

    task automatic do_reset();
        @(negedge HCLK);
        HRESETn = 0;
        idle_inputs();
        repeat (3) @(posedge HCLK);
        #1;
        chk("rst_hgrant0", HGRANT0, 0);
        chk("rst_hgrant1", HGRANT1, 0);
        chk("rst_htrans", HTRANS, 0);
        chk("rst_hmaster", HMASTER, 0);
        chk("rst_haddr", HADDR, 0);
        chk("rst_hwdata", HWDATA, HWDATA_M0);
        @(negedge HCLK);
        HRESETn = 1;
        model_reset();
    endtask

    initial begin
        logic [1:0] et;
        logic [AW-1:0] ea;
        logic ew;
        logic [2:0] es, eb;
        logic [3:0] ep;

        HRESETn = 0;
        idle_inputs();
        do_reset();

        // M0 alone: grant one cycle later, address pass-through
        @(negedge HCLK);
        HBUSREQ0 = 1;
        @(posedge HCLK); #1;
        chk("m0_grant", HGRANT0, 1);
        chk("m0_hgrant1_low", HGRANT1, 0);
        @(negedge HCLK);
        HTRANS_M0 = 2'b10; HADDR_M0 = 32'h4; HWRITE_M0 = 1;
        HSIZE_M0 = 3'd2; HPROT_M0 = 4'h3;
        HADDR_M1 = 32'hDEAD_0000; HTRANS_M1 = 2'b10;
        #1;
        chk("m0_haddr", HADDR, 32'h4);
        chk("m0_htrans", HTRANS, 2'b10);
        chk("m0_hwrite", HWRITE, 1);
        chk("m0_hsize", HSIZE, 3'd2);
        chk("m0_hprot", HPROT, 4'h3);
        @(posedge HCLK);
        @(negedge HCLK);
        HWDATA_M0 = 32'hCAFE_0004;
        #1;
        chk("m0_hwdata", HWDATA, 32'hCAFE_0004);
        // asynchronous reset in the middle of an owned cycle
        #2 HRESETn = 0;
        #1;
        chk("async_hgrant0", HGRANT0, 0);
        chk("async_htrans", HTRANS, 0);
        chk("async_haddr", HADDR, 0);
        chk("async_hmaster", HMASTER, 0);
        do_reset();

`ifdef AHB_ARB_FIXED_PRIO_EN
        tbl.push_back(v(1,1,0,0,1, 1,0,0,0));
        for (int i = 0; i < 6; i++) tbl.push_back(v(1,1,2,0,1, 1,0,0,0));
        tbl.push_back(v(0,1,0,0,1, 0,1,1,0));
        for (int i = 0; i < 4; i++) tbl.push_back(v(1,1,0,2,1, 0,1,1,1));
        tbl.push_back(v(1,1,0,2,1, 1,0,0,1));
        tbl.push_back(v(0,0,0,0,1, 0,0,0,0));
`else
        tbl.push_back(v(1,0,0,0,1, 1,0,0,0));
        tbl.push_back(v(1,0,2,0,1, 1,0,0,0));
        tbl.push_back(v(0,0,0,0,1, 0,0,0,0));
        tbl.push_back(v(1,1,0,0,1, 1,0,0,0));
        for (int i = 0; i < 4; i++) tbl.push_back(v(1,1,2,0,1, 1,0,0,0));
        tbl.push_back(v(1,1,2,0,1, 0,1,1,0));
        tbl.push_back(v(1,1,0,2,1, 0,1,1,1));
        tbl.push_back(v(1,0,0,0,1, 1,0,0,1));
        tbl.push_back(v(1,1,2,0,1, 1,0,0,0));
        for (int i = 0; i < 3; i++) tbl.push_back(v(1,1,3,0,1, 1,0,0,0));
        tbl.push_back(v(1,1,0,0,1, 0,1,1,0));
        for (int i = 0; i < 5; i++) tbl.push_back(v(1,0,0,0,0, 0,1,1,0));
        tbl.push_back(v(1,0,0,0,1, 1,0,0,1));
        tbl.push_back(v(0,0,0,0,1, 0,0,0,0));
        tbl.push_back(v(1,1,0,0,1, 0,1,1,0));
        tbl.push_back(v(0,0,0,0,1, 0,0,1,1));
`endif

        foreach (tbl[i]) begin
            @(negedge HCLK);
            HBUSREQ0 = tbl[i].r0; HBUSREQ1 = tbl[i].r1;
            HTRANS_M0 = tbl[i].t0; HTRANS_M1 = tbl[i].t1;
            HREADY = tbl[i].rdy;
            @(posedge HCLK); #1;
            chk($sformatf("tbl%0d_hgrant0", i), HGRANT0, tbl[i].g0);
            chk($sformatf("tbl%0d_hgrant1", i), HGRANT1, tbl[i].g1);
            chk($sformatf("tbl%0d_hmaster", i), HMASTER, tbl[i].hm);
            chk($sformatf("tbl%0d_hwdata", i), HWDATA,
                tbl[i].dw ? HWDATA_M1 : HWDATA_M0);
        end

        do_reset();
        for (int c = 0; c < 800; c++) begin
            @(negedge HCLK);
            HBUSREQ0 = ($urandom_range(0, 9) < 7);
            HBUSREQ1 = ($urandom_range(0, 9) < 7);
            HTRANS_M0 = 2'($urandom_range(0, 3));
            HTRANS_M1 = 2'($urandom_range(0, 3));
            HREADY = ($urandom_range(0, 9) < 8);
            HADDR_M0 = $urandom; HADDR_M1 = $urandom;
            HWRITE_M0 = 1'($urandom); HWRITE_M1 = 1'($urandom);
            HSIZE_M0 = 3'($urandom); HSIZE_M1 = 3'($urandom);
            HBURST_M0 = 3'($urandom); HBURST_M1 = 3'($urandom);
            HPROT_M0 = 4'($urandom); HPROT_M1 = 4'($urandom);
            HWDATA_M0 = $urandom; HWDATA_M1 = $urandom;
            #1;
            if (m_owner == 0) begin
                et = HTRANS_M0; ea = HADDR_M0; ew = HWRITE_M0;
                es = HSIZE_M0; eb = HBURST_M0; ep = HPROT_M0;
            end else if (m_owner == 1) begin
                et = HTRANS_M1; ea = HADDR_M1; ew = HWRITE_M1;
                es = HSIZE_M1; eb = HBURST_M1; ep = HPROT_M1;
            end else begin
                et = 0; ea = 0; ew = 0; es = 0; eb = 0; ep = 0;
            end
            chk("rnd_hgrant0", HGRANT0, m_owner == 0);
            chk("rnd_hgrant1", HGRANT1, m_owner == 1);
            chk("rnd_hmaster", HMASTER, m_hm);
            chk("rnd_htrans", HTRANS, et);
            chk("rnd_haddr", HADDR, ea);
            chk("rnd_hwrite", HWRITE, ew);
            chk("rnd_hsize", HSIZE, es);
            chk("rnd_hburst", HBURST, eb);
            chk("rnd_hprot", HPROT, ep);
            chk("rnd_hwdata", HWDATA, m_dw ? HWDATA_M1 : HWDATA_M0);
            @(posedge HCLK);
            model_step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ahb_bus_arbiter.md
Name: ahb_bus_arbiter

Overview:
- Two-master AHB arbiter placed in front of the AHB top-level slave subsystem (decoder, mux, register file and timer slaves).
- Grants the single address/control path to one requester (e.g. CPU on M0, DMA on M1) and muxes that master's address-phase signals onto the shared bus.
- Tracks the data-phase owner separately so HWDATA follows the pipelined transfer.
- Round-robin by default; holds the bus through bursts; enforces a maximum tenure.

Parameters:
- DATA_WIDTH, 32, HWDATA width.
- ADDR_WIDTH, 32, HADDR width.
- MAX_HOLD, 16, cycles a master may own the bus while the other requests before it must yield at the next non-SEQ boundary.

Ports:
- HCLK  in  1  bus clock.
- HRESETn  in  1  asynchronous active-low reset.
- HBUSREQ0 / HBUSREQ1  in  1 each  bus request from M0 / M1.
- HGRANT0 / HGRANT1  out  1 each  registered grant to M0 / M1.
- HADDR_M0 / HADDR_M1  in  ADDR_WIDTH  master address.
- HTRANS_M0 / HTRANS_M1  in  2  master transfer type.
- HWRITE_M0 / HWRITE_M1  in  1  master direction.
- HSIZE_M0 / HSIZE_M1  in  3  master size.
- HBURST_M0 / HBURST_M1  in  3  master burst type.
- HPROT_M0 / HPROT_M1  in  4  master protection.
- HWDATA_M0 / HWDATA_M1  in  DATA_WIDTH  master write data.
- HREADY  in  1  shared ready from the slave-side mux.
- HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT  out  as above  muxed address phase.
- HWDATA  out  DATA_WIDTH  muxed write data (data-phase owner).
- HMASTER  out  1  current address-phase owner.

Behaviour:
- Clock and reset: single clock HCLK, rising edge; reset HRESETn is asynchronous, active-low.
- Reset values:
  - state = PARK; HGRANT0 = HGRANT1 = 0; HMASTER = 0.
  - data_owner = 0; rr_ptr = 0 (M0 preferred next); hold_cnt = 0.
  - HTRANS = IDLE (2'b00); HADDR, HWRITE, HSIZE, HBURST, HPROT = 0; HWDATA = HWDATA_M0.
- States: PARK, OWN0, OWN1.
- PARK:
  - No grant; address outputs forced to IDLE/zero.
  - On an edge with any request, move to OWNx. Winner on simultaneous requests = rr_ptr.
  - Grant latency = 1 cycle after request is sampled.
- OWNx:
  - HGRANTx = 1, HMASTER = x; address-phase outputs pass master x's signals combinationally.
  - Masters drive NONSEQ only while their grant is high.
- Arbitration point: HREADY = 1 and HTRANS_Mx != SEQ (and != BUSY). Burst beats never split.
- At an arbitration point, the next state is:
  - other master requesting and (HBUSREQx = 0 or hold_cnt >= MAX_HOLD): OWN(other), rr_ptr = x.
  - else HBUSREQx = 1: stay in OWNx.
  - else neither master requesting: PARK.
- hold_cnt:
  - Clears on every ownership change.
  - Otherwise increments each cycle in OWNx while the other master requests; saturates at MAX_HOLD.
- HREADY = 0 freezes state, grants, hold_cnt and data_owner.
- Data phase: data_owner <= HMASTER on every edge with HREADY = 1; HWDATA mux is selected by data_owner. Across a handover, HWDATA stays with the old master for exactly one data phase.
- If a granted master drops its request mid-burst, the burst still completes (SEQ blocks switching).
- Reset asserted mid-transfer: all outputs return to reset values immediately (asynchronous); no partial grant survives.

Optional Feature:
- Macro: AHB_ARB_FIXED_PRIO_EN.
- Defined: M0 always wins simultaneous requests; MAX_HOLD preemption applies only to M1 (M1 yields to M0); rr_ptr unused.
- Undefined: round-robin as above.

Test Plan:
- Reset: HRESETn low for 3 cycles -> HGRANT0/1 = 0, HTRANS = IDLE, HMASTER = 0, HADDR = 0.
- M0 alone requests, NONSEQ write to 0x0000_0004 -> HGRANT0 = 1 one cycle later; HADDR = 0x4; next HREADY edge HWDATA = HWDATA_M0.
- Both request continuously, single transfers -> ownership alternates M0, M1, M0, ...; each handover leaves HWDATA on the old master for one cycle.
- M0 INCR4 (NONSEQ + 3 SEQ) with M1 requesting from the first beat -> HGRANT1 rises only after the 4th beat is accepted; hold_cnt is ignored during SEQ beats.
- HREADY held low 5 cycles during a handover -> state, grants and data_owner are unchanged until HREADY = 1.
- M0 issues INCR single beats indefinitely while M1 requests, MAX_HOLD = 4 -> M1 granted after the 4th held cycle at a non-SEQ boundary; with AHB_ARB_FIXED_PRIO_EN defined and M1 owning, M1 yields to M0 at the same point.
